ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It is the counterpart of the keyboard receiver: it sends command bytes to the keyboard, such as set-LEDs 0xED, enable 0xF4 and reset 0xFF. It drives the shared open-collector PS/2 clock and data lines through active-high pull-low enables, and reports the device acknowledge bit. It sits beside the keyboard receiver at top level. While a transfer is in progress it raises rx_inhibit so the receiver ignores bus activity.

Parameters:
INHIBIT_CYCLES, 5000, cycles the clock line is held low before the request (100 us at 50 MHz).
REQ_CYCLES, 50, cycles clock and data are both held low before the clock is released.
TIMEOUT_CYCLES, 750000, maximum cycles between device clock falling edges, and from request to the first edge (15 ms).

Ports:
Clk  in  1  system clock, 50 MHz.
Reset_n  in  1  synchronous active-low reset.
tx_start  in  1  one-cycle request; accepted only when tx_busy=0.
tx_data  in  8  byte to send; sampled on the cycle tx_start is accepted.
tx_busy  out  1  high from the accept cycle through the tx_done cycle.
tx_done  out  1  one-cycle pulse at the end of a transfer.
tx_err  out  1  valid with tx_done; 1 = timeout or missing acknowledge.
rx_inhibit  out  1  equals tx_busy; keyboard receiver discards frames while high.
ps2_clk_in  in  1  raw PS/2 clock line (asynchronous).
ps2_dat_in  in  1  raw PS/2 data line (asynchronous).
ps2_clk_oe  out  1  1 = pull clock low, 0 = release.
ps2_dat_oe  out  1  1 = pull data low, 0 = release.

Behaviour:
- Reset (Reset_n=0 sampled on a Clk edge): state IDLE, all outputs 0, both lines released, counters cleared. This holds even mid-transfer; there is no tx_done for an aborted frame.
- Line inputs: 2-FF synchronizer per line. A falling edge (fall) is sync_prev=1 and sync_cur=0. Minimum latency is 2 cycles.
- Shift register: on accept, load {1'b1 stop, odd parity = ~^tx_data, tx_data}, 10 bits, LSB first.
- IDLE: all outputs 0. tx_start -> INHIBIT; tx_busy=1; counter cleared. tx_start while busy is ignored and the byte is lost.
- INHIBIT: clk_oe=1, dat_oe=0. After INHIBIT_CYCLES cycles -> REQ.
- REQ: clk_oe=1, dat_oe=1 (start bit 0). After REQ_CYCLES cycles -> SEND; clk_oe=0; bit index=0; timeout counter cleared.
- SEND: on each fall, dat_oe = ~shift[0], then shift right and increment the index. Falls 1..8 present data bits, fall 9 presents parity, fall 10 presents stop (dat_oe=0). After fall 10 -> ACK.
- ACK: on the next fall, sample sync data. If 0 (acknowledged), ack_ok=1. Go to WAIT_IDLE.
- WAIT_IDLE: wait until both synced lines are 1 for 1 cycle. Then go to DONE.
- DONE: one cycle with tx_done=1 and tx_err=~ack_ok. Next state IDLE; tx_busy drops the cycle after DONE.
- Timeout: in SEND, ACK and WAIT_IDLE the counter increments each cycle and clears on fall. Reaching TIMEOUT_CYCLES releases both lines and goes to DONE with tx_err=1.
- Bus-contention rule: oe outputs change only on state transitions or falls. They are glitch-free and registered.
- Counter width is $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1). It saturates and never wraps.

Decomposition:
- ps2_pkg:
  - state enum tx_state_t {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE}.
  - Command constants CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, RSP_ACK=8'hFA.
  - Function odd_parity(byte).
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge detector, instantiated per line. The receiver reuses it.

Test Plan:
1. Send tx_data=8'hED. The device model clocks at 12.5 kHz and acks.
   - Clock is held low for at least 5000 cycles before data goes low.
   - Data bits seen at the device are 1,0,1,1,0,1,1,1, then parity=1, then stop=1.
   - tx_done=1, tx_err=0; tx_busy is high throughout.
2. Send 8'hF4. Parity bit at the device = 0. Normal ack gives tx_err=0.
3. The device never clocks after REQ.
   - At exactly TIMEOUT_CYCLES after the clock is released: tx_done=1, tx_err=1, both oe=0.
4. The device clocks all 11 bits but leaves data high on the ack bit -> tx_done with tx_err=1.
5. Assert tx_start with 8'h00 while busy sending 8'hFF -> the second request is ignored and the frame carries 8'hFF.
6. Drive Reset_n=0 during SEND bit 4 -> the next cycle has both oe=0, tx_busy=0 and no tx_done. A fresh tx_start afterwards completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command codes and parity helper
// Purpose: state encoding for the host transmitter, keyboard command and
//          response codes, and the odd-parity function used to build frames.
// Ports:   none (package).
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SEND,
      ACK,
      WAIT_IDLE,
      DONE
   } tx_state_t;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RSP_ACK      = 8'hFA;

   // Odd parity: the returned bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizer with falling-edge detect for one PS/2 line
// Purpose: bring an asynchronous open-collector line into the clk domain and
//          flag its high-to-low transitions.
// Ports:   clk    - system clock
//          resetn - synchronous active-low reset
//          line   - raw asynchronous line
//          sync   - synchronized line level
//          fall   - one-cycle pulse when the synchronized level drops 1 -> 0
module ps2_line_sync (
   input  logic clk,
   input  logic resetn,
   input  logic line,
   output logic sync,
   output logic fall
);

   logic meta;
   logic prev;

   // Reset to 1 (the idle bus level) so leaving reset never reports a fall.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= line;
         sync <= meta;
         prev <= sync;
      end
   end

   assign fall = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Purpose: sends one command byte to a PS/2 device (inhibit, request-to-send,
//          10 device-clocked bits, acknowledge) and reports success or error.
// Ports:   Clk, Reset_n           - system clock, synchronous active-low reset
//          tx_start, tx_data      - one-cycle request and byte to send
//          tx_busy, tx_done       - transfer in progress / end-of-transfer pulse
//          tx_err                 - with tx_done: timeout or missing acknowledge
//          rx_inhibit             - tells the keyboard receiver to ignore the bus
//          ps2_clk_in, ps2_dat_in - raw bus lines
//          ps2_clk_oe, ps2_dat_oe - 1 = pull the line low
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned REQ_CYCLES     = 50,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err,
   output logic       rx_inhibit,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int unsigned MAX_COUNT =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW = $clog2(MAX_COUNT + 1);

   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] REQ_LAST = CW'(REQ_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   tx_state_t      state, state_n;
   logic [CW-1:0]  cnt, cnt_n, cnt_inc;
   logic [9:0]     shift, shift_n;
   logic [3:0]     idx, idx_n;
   logic           ack_ok, ack_ok_n;
   logic           clk_oe_n, dat_oe_n, err_n;
   logic           clk_sync, clk_fall, dat_sync, dat_fall;

   ps2_line_sync u_clk_sync (
      .clk    (Clk),
      .resetn (Reset_n),
      .line   (ps2_clk_in),
      .sync   (clk_sync),
      .fall   (clk_fall)
   );

   ps2_line_sync u_dat_sync (
      .clk    (Clk),
      .resetn (Reset_n),
      .line   (ps2_dat_in),
      .sync   (dat_sync),
      .fall   (dat_fall)
   );

   assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   assign rx_inhibit = tx_busy;

   // Line enables are computed here and registered below, and only move on a
   // state change or a device clock fall.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      shift_n  = shift;
      idx_n    = idx;
      ack_ok_n = ack_ok;
      clk_oe_n = ps2_clk_oe;
      dat_oe_n = ps2_dat_oe;
      err_n    = 1'b0;
      case (state)
         IDLE: begin
            if (tx_start) begin
               state_n  = INHIBIT;
               cnt_n    = '0;
               shift_n  = {1'b1, odd_parity(tx_data), tx_data};
               idx_n    = '0;
               ack_ok_n = 1'b0;
               clk_oe_n = 1'b1;
               dat_oe_n = 1'b0;
            end
         end
         INHIBIT: begin
            cnt_n = cnt_inc;
            if (cnt == INH_LAST) begin
               state_n  = REQ;
               cnt_n    = '0;
               dat_oe_n = 1'b1;
            end
         end
         REQ: begin
            cnt_n = cnt_inc;
            if (cnt == REQ_LAST) begin
               state_n  = SEND;
               cnt_n    = '0;
               idx_n    = '0;
               clk_oe_n = 1'b0;
            end
         end
         SEND, ACK, WAIT_IDLE: begin
            if (state == WAIT_IDLE && clk_sync && dat_sync) begin
               state_n  = DONE;
               err_n    = ~ack_ok;
               clk_oe_n = 1'b0;
               dat_oe_n = 1'b0;
            end else if (clk_fall) begin
               cnt_n = '0;
               if (state == SEND) begin
                  dat_oe_n = ~shift[0];
                  shift_n  = {1'b0, shift[9:1]};
                  idx_n    = idx + 4'd1;
                  if (idx == 4'd9) state_n = ACK;
               end else if (state == ACK) begin
                  ack_ok_n = ~dat_sync;
                  state_n  = WAIT_IDLE;
               end
            end else if (cnt == TO_LAST) begin
               state_n  = DONE;
               err_n    = 1'b1;
               clk_oe_n = 1'b0;
               dat_oe_n = 1'b0;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         DONE: begin
            state_n  = IDLE;
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b0;
         end
         default: begin
            state_n  = IDLE;
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         shift      <= '0;
         idx        <= '0;
         ack_ok     <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
         tx_err     <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         shift      <= shift_n;
         idx        <= idx_n;
         ack_ok     <= ack_ok_n;
         ps2_clk_oe <= clk_oe_n;
         ps2_dat_oe <= dat_oe_n;
         tx_busy    <= (state_n != IDLE);
         tx_done    <= (state_n == DONE);
         tx_err     <= err_n;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH  = 40;
   localparam int REQ  = 8;
   localparam int TO   = 600;
   localparam int HALF = 20;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_busy, tx_done, tx_err, rx_inhibit;
   logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .REQ_CYCLES     (REQ),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_err     (tx_err),
      .rx_inhibit (rx_inhibit),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   always #10 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [7:0] data;
      bit         ack;
      logic       par;
      logic       err;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_tx(input logic [7:0] d);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge Clk);
      tx_start = 1'b0;
   endtask

   // Device side: measures inhibit, clocks 11 bits, samples on rising edges.
   task automatic dev_frame(input bit do_ack, output logic [9:0] bits,
                            output int inh_len, output bit ok);
      int n;
      ok = 1'b1;
      bits = '0;
      inh_len = 0;
      n = 0;
      while (!ps2_clk_oe && n < 200) begin @(negedge Clk); n++; end
      while (ps2_clk_oe && !ps2_dat_oe && inh_len < 10000) begin
         @(negedge Clk);
         inh_len++;
      end
      n = 0;
      while (ps2_clk_oe && n < 1000) begin @(negedge Clk); n++; end
      if (ps2_clk_oe || !ps2_dat_oe) ok = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         repeat (HALF / 2) @(negedge Clk);
         if (k == 11 && do_ack) dev_dat = 1'b0;
         repeat (HALF / 2) @(negedge Clk);
         dev_clk = 1'b0;
         repeat (HALF) @(negedge Clk);
         dev_clk = 1'b1;
         if (k <= 10) bits[k-1] = ps2_dat_in;
      end
      repeat (HALF / 2) @(negedge Clk);
      dev_dat = 1'b1;
   endtask

   task automatic wait_done(input int budget, output bit seen, output logic err,
                            output bit busy_ok);
      seen = 1'b0;
      err = 1'b0;
      busy_ok = 1'b1;
      for (int n = 0; n < budget && !seen; n++) begin
         if (!tx_busy || !rx_inhibit) busy_ok = 1'b0;
         if (tx_done) begin
            seen = 1'b1;
            err = tx_err;
         end else begin
            @(negedge Clk);
         end
      end
   endtask

   initial begin
      logic [9:0] bits;
      int         inh;
      bit         ok, seen, busy_ok, late_done;
      logic       err;
      int         t_rel, n;

      vecs[0] = '{data: 8'hED, ack: 1'b1, par: 1'b1, err: 1'b0};
      vecs[1] = '{data: 8'hF4, ack: 1'b1, par: 1'b0, err: 1'b0};
      vecs[2] = '{data: 8'h00, ack: 1'b0, par: 1'b1, err: 1'b1};
      vecs[3] = '{data: 8'h01, ack: 1'b1, par: 1'b0, err: 1'b0};

      repeat (3) @(negedge Clk);
      check("reset tx_busy", tx_busy, 0);
      check("reset tx_done", tx_done, 0);
      check("reset tx_err", tx_err, 0);
      check("reset rx_inhibit", rx_inhibit, 0);
      check("reset clk_oe", ps2_clk_oe, 0);
      check("reset dat_oe", ps2_dat_oe, 0);
      Reset_n = 1'b1;
      repeat (2) @(negedge Clk);

      check("pkg set_leds", ps2_pkg::CMD_SET_LEDS, 8'hED);
      check("pkg parity ED", ps2_pkg::odd_parity(vecs[0].data), 1);

      for (int i = 0; i < 4; i++) begin
         start_tx(vecs[i].data);
         fork
            dev_frame(vecs[i].ack, bits, inh, ok);
            wait_done(4000, seen, err, busy_ok);
         join
         check($sformatf("v%0d done", i), seen, 1);
         check($sformatf("v%0d err", i), err, vecs[i].err);
         check($sformatf("v%0d busy", i), busy_ok, 1);
         check($sformatf("v%0d data", i), bits[7:0], vecs[i].data);
         check($sformatf("v%0d parity", i), bits[8], vecs[i].par);
         check($sformatf("v%0d stop", i), bits[9], 1);
         check($sformatf("v%0d handshake", i), ok, 1);
         check($sformatf("v%0d inhibit_len", i), (inh >= INH), 1);
         @(negedge Clk);
         check($sformatf("v%0d busy_drop", i), tx_busy, 0);
         repeat (5) @(negedge Clk);
      end

      // Device never clocks: timeout exactly TO cycles after clock release.
      start_tx(ps2_pkg::CMD_ENABLE);
      n = 0;
      while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < 1000) begin
         @(negedge Clk);
         n++;
      end
      t_rel = cyc;
      wait_done(TO + 100, seen, err, busy_ok);
      check("timeout done", seen, 1);
      check("timeout latency", cyc - t_rel, TO);
      check("timeout err", err, 1);
      check("timeout clk_oe", ps2_clk_oe, 0);
      check("timeout dat_oe", ps2_dat_oe, 0);
      @(negedge Clk);
      check("timeout busy_drop", tx_busy, 0);
      repeat (5) @(negedge Clk);

      // Second request while busy is dropped.
      start_tx(ps2_pkg::CMD_RESET);
      fork
         dev_frame(1'b1, bits, inh, ok);
         wait_done(4000, seen, err, busy_ok);
         begin
            repeat (10) @(negedge Clk);
            tx_data  = 8'h00;
            tx_start = 1'b1;
            @(negedge Clk);
            tx_start = 1'b0;
         end
      join
      check("busy_start done", seen, 1);
      check("busy_start err", err, 0);
      check("busy_start data", bits[7:0], 8'hFF);
      check("busy_start parity", bits[8], 1);
      late_done = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge Clk);
         if (tx_busy || ps2_clk_oe) late_done = 1'b1;
      end
      check("busy_start no_second_frame", late_done, 0);

      // Reset during SEND after the 4th device clock fall.
      start_tx(ps2_pkg::CMD_SET_LEDS);
      n = 0;
      while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < 1000) begin
         @(negedge Clk);
         n++;
      end
      for (int k = 0; k < 4; k++) begin
         repeat (HALF) @(negedge Clk);
         dev_clk = 1'b0;
         repeat (HALF) @(negedge Clk);
         dev_clk = 1'b1;
      end
      check("abort mid_send busy", tx_busy, 1);
      Reset_n = 1'b0;
      @(negedge Clk);
      check("abort clk_oe", ps2_clk_oe, 0);
      check("abort dat_oe", ps2_dat_oe, 0);
      check("abort busy", tx_busy, 0);
      check("abort done", tx_done, 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      late_done = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge Clk);
         if (tx_done || tx_busy) late_done = 1'b1;
      end
      check("abort no_done", late_done, 0);

      start_tx(8'hED);
      fork
         dev_frame(1'b1, bits, inh, ok);
         wait_done(4000, seen, err, busy_ok);
      join
      check("after_abort done", seen, 1);
      check("after_abort err", err, 0);
      check("after_abort data", bits[7:0], 8'hED);
      check("after_abort parity", bits[8], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
